// File: rtl/lc3b_pkg.sv
// Shared LC-3b memory-interface definitions: FSM encoding, byte enables, size codes.
// Pure declarations, no logic.
// Optional feature macro used by importers: LC3B_MEM_UNALIGNED_TRAP_EN.
package lc3b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  // Byte enables for an access of the given size at the given address LSB.
  function automatic logic [1:0] be_for(input logic size, input logic a0);
    return (size == SIZE_WORD) ? BE_WORD : (a0 ? BE_HI : BE_LO);
  endfunction

endpackage

// File: rtl/lc3b_byte_sext.sv
// Byte-select and sign-extend of a 16-bit memory word (GateMDR / load path).
// Latency: combinational, 0 cycles.
// Backpressure: none, pure function of its inputs.
import lc3b_pkg::*;

module lc3b_byte_sext (
  input  logic [15:0] data_i,
  input  logic        size_i,
  input  logic        a0_i,
  output logic [15:0] data_o
);

  logic [7:0] byte_sel;

  // Pick the addressed byte and sign-extend it unless this is a word access.
  always_comb begin
    byte_sel = a0_i ? data_i[15:8] : data_i[7:0];
    if (size_i == SIZE_WORD) begin
      data_o = data_i;
    end else begin
      data_o = {{8{byte_sel[7]}}, byte_sel};
    end
  end

endmodule

// File: rtl/lc3b_mem_if.sv
// LC-3b memory-interface stage: MAR/MDR plus the multi-cycle request/ready handshake.
// Latency: mio_en sampled in IDLE -> r after 3 + N edges (N = WAIT cycles before mem_ready).
// Backpressure: holds mem_req until mem_ready or MAX_WAIT timeout; LC3B_MEM_UNALIGNED_TRAP_EN adds the unaligned trap.
import lc3b_pkg::*;

module lc3b_mem_if #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        data_size,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] mar,
  output logic [15:0] mdr_gate,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        r,
`ifdef LC3B_MEM_UNALIGNED_TRAP_EN
  output logic        unaligned,
`endif
  output logic        mem_err
);

  localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [15:0] mar_q;
  logic [15:0] mdr_q;
  logic [15:0] acc_addr_q;
  logic        acc_we_q;
  logic        acc_size_q;
  logic        acc_a0_q;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic        start;
  logic        timeout;
`ifdef LC3B_MEM_UNALIGNED_TRAP_EN
  logic        trap;
  logic        unal_q;
`endif

  // State register; reset drops any in-flight access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; mio_en only matters in IDLE, completion beats timeout.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    timeout = 1'b0;
`ifdef LC3B_MEM_UNALIGNED_TRAP_EN
    trap    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mio_en) begin
          start   = 1'b1;
          state_d = ST_REQ;
`ifdef LC3B_MEM_UNALIGNED_TRAP_EN
          if (data_size == SIZE_WORD && mar_q[0]) begin
            trap    = 1'b1;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_ready) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          timeout = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: MAR, MDR, latched access attributes, wait counter, error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_q      <= 16'h0000;
      mdr_q      <= 16'h0000;
      acc_addr_q <= 16'h0000;
      acc_we_q   <= 1'b0;
      acc_size_q <= 1'b0;
      acc_a0_q   <= 1'b0;
      cnt_q      <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      if (ld_mar) mar_q <= bus_in;
      if (ld_mdr && !mio_en) begin
        mdr_q <= (data_size == SIZE_WORD) ? bus_in : {bus_in[7:0], bus_in[7:0]};
      end else if (state_q == ST_WAIT && mem_ready && !acc_we_q && ld_mdr) begin
        mdr_q <= mem_rdata;
      end
      if (start) begin
        acc_addr_q <= mar_q;
        acc_we_q   <= r_w;
        acc_size_q <= data_size;
        acc_a0_q   <= mar_q[0];
      end
      cnt_q <= (state_q == ST_WAIT) ? cnt_q + 8'd1 : 8'h00;
      if (timeout) err_q <= 1'b1;
    end
  end

`ifdef LC3B_MEM_UNALIGNED_TRAP_EN
  // One-cycle unaligned flag, aligned with the DONE cycle of a trapped access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) unal_q <= 1'b0;
    else        unal_q <= trap;
  end
  assign unaligned = unal_q;
`endif

  // Moore outputs decoded from registered state; address stays latched while busy.
  always_comb begin
    mem_req   = (state_q == ST_REQ) || (state_q == ST_WAIT);
    mem_we    = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && acc_we_q;
    mem_be    = ((state_q == ST_REQ) || (state_q == ST_WAIT)) ? be_for(acc_size_q, acc_a0_q) : 2'b00;
    r         = (state_q == ST_DONE);
    mem_addr  = (state_q == ST_IDLE) ? mar_q : acc_addr_q;
    mem_wdata = mdr_q;
    mar       = mar_q;
    mem_err   = err_q;
  end

  lc3b_byte_sext u_sext (
    .data_i (mdr_q),
    .size_i (data_size),
    .a0_i   (mar_q[0]),
    .data_o (mdr_gate)
  );

endmodule

// File: tb/tb_lc3b_mem_if.sv
`timescale 1ns/1ps
module tb_lc3b_mem_if;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bus_in = '0;
  logic        ld_mar = 1'b0, ld_mdr = 1'b0, mio_en = 1'b0, r_w = 1'b0, data_size = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] mar, mdr_gate, mem_addr, mem_wdata;
  logic        mem_req, mem_we, r, mem_err;
  logic [1:0]  mem_be;
`ifdef LC3B_MEM_UNALIGNED_TRAP_EN
  logic        unaligned;
`endif

  always #5 clk = ~clk;

  lc3b_mem_if #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .data_size(data_size), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mar(mar), .mdr_gate(mdr_gate), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .r(r),
`ifdef LC3B_MEM_UNALIGNED_TRAP_EN
    .unaligned(unaligned),
`endif
    .mem_err(mem_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: what MAR, MDR and the error flag should hold.
  logic [15:0] m_mar = '0;
  logic [15:0] m_mdr = '0;
  logic        m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // GateMDR value from the addressing rules, using plain arithmetic.
  function automatic logic [15:0] ref_gate(input logic [15:0] mdr, input logic size, input logic a0);
    int b;
    if (size) return mdr;
    b = a0 ? int'(mdr) / 256 : int'(mdr) % 256;
    return (b >= 128) ? 16'(b + 32'hFF00) : 16'(b);
  endfunction

  function automatic logic [1:0] ref_be(input logic size, input logic a0);
    return size ? 2'd3 : (a0 ? 2'd2 : 2'd1);
  endfunction

  task automatic load_mar(input logic [15:0] v);
    @(negedge clk); bus_in = v; ld_mar = 1'b1;
    @(negedge clk); ld_mar = 1'b0;
    m_mar = v;
  endtask

  task automatic load_mdr_bus(input logic [15:0] v, input logic size);
    @(negedge clk); bus_in = v; data_size = size; mio_en = 1'b0; ld_mdr = 1'b1;
    @(negedge clk); ld_mdr = 1'b0;
    m_mdr = size ? v : 16'((int'(v) % 256) * 257);
  endtask

  // One memory access; d = index of the WAIT cycle carrying mem_ready (>= MAXW means never).
  task automatic access(input string tag, input logic rw, input logic size, input int d,
                        input logic [15:0] rdata, input logic mid_mar, input logic [15:0] new_mar);
    logic [15:0] acc_addr;
    int  exp_lat;
    int  e;
    bit  got_r;
    bit  trap;
    bit  mm;
    acc_addr = m_mar;
    trap  = 1'b0;
`ifdef LC3B_MEM_UNALIGNED_TRAP_EN
    trap  = size && m_mar[0];
`endif
    mm    = mid_mar && (d >= 1) && !trap;
    exp_lat = trap ? 1 : ((d < MAXW) ? 3 + d : 2 + MAXW);
    e = 0;
    got_r = 1'b0;
    @(negedge clk);
    mio_en = 1'b1; r_w = rw; data_size = size; ld_mdr = !rw;
    mem_ready = 1'b0; mem_rdata = 16'($urandom);
    while (!got_r && e < 40) begin
      @(posedge clk); e++; #1;
      if (r) begin
        got_r = 1'b1;
      end else begin
        if (e == 1) begin
          check({tag, "_req"},   mem_req, 1);
          check({tag, "_we"},    mem_we, rw);
          check({tag, "_be"},    mem_be, ref_be(size, acc_addr[0]));
          check({tag, "_addr"},  mem_addr, acc_addr);
          check({tag, "_wdata"}, mem_wdata, m_mdr);
        end
        if (mm && e == 2) begin ld_mar = 1'b1; bus_in = new_mar; end
        if (mm && e == 3) begin
          ld_mar = 1'b0; m_mar = new_mar;
          check({tag, "_mar_mid"},  mar, new_mar);
          check({tag, "_addr_mid"}, mem_addr, acc_addr);
        end
        // Also pulse mem_ready during REQ with junk data; it must be ignored.
        mem_ready = (e >= 2 && e - 2 == d) || (e == 1 && d >= 1);
        mem_rdata = (e >= 2 && e - 2 == d) ? rdata : 16'($urandom);
      end
    end
    check({tag, "_r_seen"}, 32'(got_r), 1);
    check({tag, "_lat"}, e, exp_lat);
    if (!trap && d < MAXW && !rw) m_mdr = rdata;
    if (!trap && d >= MAXW) m_err = 1'b1;
    check({tag, "_err"},     mem_err, m_err);
    check({tag, "_gate"},    mdr_gate, ref_gate(m_mdr, size, m_mar[0]));
    check({tag, "_req_dn"},  mem_req, 0);
    check({tag, "_wdat_dn"}, mem_wdata, m_mdr);
`ifdef LC3B_MEM_UNALIGNED_TRAP_EN
    check({tag, "_unal"}, unaligned, trap);
`endif
    mio_en = 1'b0; ld_mdr = 1'b0; mem_ready = 1'b0; ld_mar = 1'b0;
    @(posedge clk); #1;
    check({tag, "_r_pulse"}, r, 0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_mar", mar, 0);
    check("rst_gate", mdr_gate, 0);
    check("rst_req", mem_req, 0);
    check("rst_r", r, 0);
    check("rst_err", mem_err, 0);
    check("rst_be", mem_be, 0);
    check("rst_addr", mem_addr, 0);
    @(negedge clk); rst_n = 1'b1;

    // Word read with two WAIT cycles before ready.
    load_mar(16'h3000);
    access("wrd_rd", 1'b0, 1'b1, 2, 16'hBEEF, 1'b0, 16'h0);

    // Byte reads, high then low byte.
    load_mar(16'h3001);
    access("byte_hi", 1'b0, 1'b0, 0, 16'h80AA, 1'b0, 16'h0);
    check("byte_hi_val", mdr_gate, 16'hFF80);
    load_mar(16'h3000);
    access("byte_lo", 1'b0, 1'b0, 1, 16'h80AA, 1'b0, 16'h0);
    check("byte_lo_val", mdr_gate, 16'hFFAA);

    // Byte write: MDR loaded from the bus replicates the low byte.
    load_mdr_bus(16'h1234, 1'b0);
    load_mar(16'h4001);
    access("byte_wr", 1'b1, 1'b0, 1, 16'h0, 1'b0, 16'h0);
    check("byte_wr_wdata", mem_wdata, 16'h3434);

    // Ready on the last allowed WAIT cycle: completion, no error.
    load_mar(16'h2000);
    access("edge_rd", 1'b0, 1'b1, MAXW - 1, 16'h5A5A, 1'b0, 16'h0);

    // Timeout: no ready ever; MDR unchanged, sticky error.
    access("tmo_rd", 1'b0, 1'b1, 99, 16'hDEAD, 1'b0, 16'h0);
    check("tmo_mdr", mem_wdata, 16'h5A5A);

    // MAR reload while an access is in flight.
    load_mar(16'h1200);
    access("mid_mar", 1'b0, 1'b1, 2, 16'h7777, 1'b1, 16'h1301);

    // Reset in the middle of WAIT.
    load_mar(16'h5000);
    @(negedge clk); mio_en = 1'b1; r_w = 1'b0; data_size = 1'b1; ld_mdr = 1'b1; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_busy", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_r", r, 0);
    check("mid_rst_mar", mar, 0);
    check("mid_rst_gate", mdr_gate, 0);
    check("mid_rst_err", mem_err, 0);
    @(negedge clk); mio_en = 1'b0; ld_mdr = 1'b0; rst_n = 1'b1;
    m_mar = '0; m_mdr = '0; m_err = 1'b0;
    load_mar(16'h6002);
    access("post_rst", 1'b0, 1'b1, 0, 16'hC0DE, 1'b0, 16'h0);

    // Randomised accesses against the reference model.
    for (int i = 0; i < 24; i++) begin
      load_mar(16'($urandom));
      if ($urandom_range(0, 2) == 0) load_mdr_bus(16'($urandom), 1'($urandom_range(0, 1)));
      access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, MAXW + 1)), 16'($urandom),
             1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lc3b_mem_if.md
# lc3b_mem_if

Memory-interface stage for the LC-3b datapath: holds MAR and MDR and runs the multi-cycle memory handshake. It drives the memory-side address, data and byte-enable signals. It also returns the R (ready) strobe that releases the microsequencer. It sits directly downstream of the 16-bit 3-input mux that drives the bus/MDR source, and consumes that mux's output as `bus_in`.

## Interface
- `MAX_WAIT`, 15: cycles to wait for `mem_ready` before aborting the access; valid range 1–255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bus_in`  in  16  datapath bus value from the upstream mux.
- `ld_mar`  in  1  load MAR from `bus_in`.
- `ld_mdr`  in  1  load MDR; source is chosen by `mio_en`.
- `mio_en`  in  1  1 = start or continue a memory access; 0 = MDR loads from the bus.
- `r_w`  in  1  1 = write, 0 = read.
- `data_size`  in  1  1 = word, 0 = byte.
- `mem_rdata`  in  16  memory read data, valid when `mem_ready` is high.
- `mem_ready`  in  1  memory completion strobe.
- `mar`  out  16  MAR contents.
- `mdr_gate`  out  16  GateMDR value for the bus.
- `mem_req`  out  1  access request; held until completion or abort.
- `mem_we`  out  1  write qualifier.
- `mem_addr`  out  16  access address; equals MAR.
- `mem_wdata`  out  16  write data; equals MDR.
- `mem_be`  out  2  byte enables, bit 1 = high byte.
- `r`  out  1  one-cycle ready pulse to the microsequencer.
- `mem_err`  out  1  sticky timeout flag.

## Operation
- **Reset:**
  - All registers and outputs go to 0.
  - FSM goes to IDLE.
- **MAR:** `mar <= bus_in` on `ld_mar`. MAR is independent of the FSM.
- **MDR from bus** (`ld_mdr=1`, `mio_en=0`):
  - Word: `MDR <= bus_in`.
  - Byte: `MDR <= {bus_in[7:0], bus_in[7:0]}`, i.e. the low byte in both halves.
- **FSM states:** IDLE, REQ, WAIT, DONE.
- **IDLE → REQ:** when `mio_en=1`. Latch `r_w`, `data_size` and `mar[0]` as the access attributes.
- **REQ:**
  - Assert `mem_req`.
  - Drive `mem_we` = latched `r_w`.
  - Drive `mem_be`: word → 2'b11; byte → `mar[0]` ? 2'b10 : 2'b01.
  - Go to WAIT.
- **WAIT:**
  - Keep `mem_req` high.
  - The wait counter increments every WAIT cycle.
  - On `mem_ready` → DONE. For a read with `ld_mdr=1`, capture `MDR <= mem_rdata` in that same cycle.
  - If the counter reaches `MAX_WAIT` with no `mem_ready` → DONE with `mem_err <= 1`; MDR is unchanged.
- **DONE:**
  - `mem_req` low.
  - `r` high for exactly one cycle.
  - Next state is IDLE.
- **`mio_en` during an access:** ignored while the FSM is in REQ, WAIT or DONE. A new access starts only from IDLE.
- **`mdr_gate`:**
  - Word: MDR.
  - Byte: sign-extended `MDR[15:8]` if `mar[0]=1`, else sign-extended `MDR[7:0]`.
- **`mem_err`:** cleared only by reset.
- **Boundary conditions:**
  - `mem_ready` in the same cycle the counter hits `MAX_WAIT`: completion wins; no error.
  - `ld_mar` during an access: MAR updates, but `mem_addr` keeps the latched access address until DONE.
  - Reset mid-access: immediate return to IDLE; `mem_req` deasserts asynchronously.
  - `mem_ready` while not in WAIT: ignored.

## Timing
- Latency from `mio_en` sampled in IDLE to `r`: 3 + N cycles, where N is the number of WAIT cycles before `mem_ready`. With `mem_ready` on the first WAIT cycle, `r` rises on the 3rd edge after the request.
- `mem_req` rises on the edge after `mio_en` is sampled. All memory-side outputs are registered.
- MDR captured from memory is visible on `mdr_gate` in the DONE cycle.
- Back-to-back accesses: the next request can be sampled in the first IDLE cycle after DONE.

## Configuration
- **`LC3B_MEM_UNALIGNED_TRAP_EN` defined:**
  - A word access with `mar[0]=1` does not issue `mem_req`.
  - The FSM goes IDLE → DONE, asserts `r`, and pulses output `unaligned` (1 bit, reset 0) high for one cycle.
- **Undefined:**
  - The `unaligned` port is absent.
  - Word accesses ignore `mar[0]`; `mem_addr` still carries the full MAR.

## Structure
- **Shared package `lc3b_pkg`:**
  - FSM state encoding (IDLE, REQ, WAIT, DONE).
  - Byte-enable constants BE_WORD, BE_LO, BE_HI.
  - Data-size encodings SIZE_BYTE and SIZE_WORD.
- **Sub-module `lc3b_byte_sext`:** the combinational byte-select and sign-extend that produces `mdr_gate`. It is reused by the load path.

## Test plan
- **Reset mid-access:** assert `rst_n=0` mid-WAIT → `mem_req`, `r`, `mar` and `mdr_gate` are 0 immediately; next access starts cleanly.
- **Word read:** `mar`=0x3000, read, word, `mem_ready` after 2 WAIT cycles with `mem_rdata`=0xBEEF, `ld_mdr`=1 → `mem_be`=11, `mdr_gate`=0xBEEF, one `r` pulse 5 cycles after the request.
- **Byte read:** `mar`=0x3001, byte read, `mem_rdata`=0x80AA → `mem_be`=10, `mdr_gate`=0xFF80. Same with `mar`=0x3000 → `mdr_gate`=0xFFAA.
- **Byte write:** `bus_in`=0x1234, `ld_mdr`, `mio_en=0`, then byte write to 0x4001 → `mem_wdata`=0x3434, `mem_be`=10, `mem_we`=1.
- **Timeout:** `MAX_WAIT`=4, `mem_ready` never asserted → `r` pulses after 4 WAIT cycles, `mem_err`=1, MDR unchanged. With `mem_ready` on the 4th WAIT cycle → `mem_err`=0.
- **Unaligned word (macro defined):** word access at 0x3001 → no `mem_req`; `unaligned` and `r` both pulse.
